// File: rtl/lab_tt_pkg.sv
// Shared types and sizes for the 7-input truth-table sweep checker.
package lab_tt_pkg;

    localparam int N_IN_DEF = 7;
    localparam int NUM_VEC  = 2**N_IN_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [N_IN_DEF-1:0] vec_t;

endpackage

// File: rtl/minterm_sweep_checker_if.sv
// Bundle between the sweep checker and its driver/FUT side: control, vector, result bus.
interface minterm_sweep_checker_if
    import lab_tt_pkg::*;
#(
    parameter int N_IN = N_IN_DEF
) ();

    logic                 start;
    logic [N_IN-1:0]      vec;
    logic                 fut_out;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [N_IN:0]        err_count;
    logic                 first_err_valid;
    logic [N_IN-1:0]      first_err_idx;
    logic [2**N_IN-1:0]   tt_cap;

    modport master (
        output start, fut_out,
        input  vec, busy, done, pass, err_count, first_err_valid, first_err_idx, tt_cap
    );

    modport slave (
        input  start, fut_out,
        output vec, busy, done, pass, err_count, first_err_valid, first_err_idx, tt_cap
    );

endinterface

// File: rtl/sweep_vector_gen.sv
// Walks vec from 0 to the all-ones vector, holding each value for SETTLE_CYCLES+1 cycles.
module sweep_vector_gen
    import lab_tt_pkg::*;
#(
    parameter int N_IN          = N_IN_DEF,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            advance,
    output logic [N_IN-1:0] vec,
    output logic            sample_now,
    output logic            last
);

    localparam logic [3:0]      SC_MAX  = 4'(SETTLE_CYCLES);
    localparam logic [N_IN-1:0] VEC_MAX = '1;

    logic [N_IN-1:0] vec_q, vec_d;
    logic [3:0]      sc_q, sc_d;

    // The last vector never increments; the owner leaves SWEEP instead of wrapping.
    always_comb begin
        vec_d = vec_q;
        sc_d  = sc_q;
        if (clear) begin
            vec_d = '0;
            sc_d  = '0;
        end else if (advance) begin
            if (sc_q != SC_MAX) begin
                sc_d = sc_q + 4'd1;
            end else if (vec_q != VEC_MAX) begin
                vec_d = vec_q + N_IN'(1);
                sc_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q <= '0;
            sc_q  <= '0;
        end else begin
            vec_q <= vec_d;
            sc_q  <= sc_d;
        end
    end

    assign vec        = vec_q;
    assign sample_now = (sc_q == SC_MAX);
    assign last       = (vec_q == VEC_MAX);

endmodule

// File: rtl/minterm_sweep_checker.sv
// Exhaustive truth-table tester: sweeps every input vector, captures the FUT output
// and scores it against EXP_TT (mismatch count, first failing minterm, pass).
module minterm_sweep_checker
    import lab_tt_pkg::*;
#(
    parameter int                 N_IN          = N_IN_DEF,
    parameter int                 SETTLE_CYCLES = 1,
    parameter logic [2**N_IN-1:0] EXP_TT        = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    minterm_sweep_checker_if.slave  bus
);

    state_t               state_q, state_d;
    logic [N_IN:0]        err_count_q, err_count_d;
    logic                 first_err_valid_q, first_err_valid_d;
    logic [N_IN-1:0]      first_err_idx_q, first_err_idx_d;
    logic [2**N_IN-1:0]   tt_cap_q, tt_cap_d;

    logic                 gen_clear;
    logic                 gen_advance;
    logic [N_IN-1:0]      vec;
    logic                 sample_now;
    logic                 last;

    sweep_vector_gen #(
        .N_IN          (N_IN),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_gen (
        .clk        (clk),
        .rst        (rst),
        .clear      (gen_clear),
        .advance    (gen_advance),
        .vec        (vec),
        .sample_now (sample_now),
        .last       (last)
    );

    always_comb begin
        state_d           = state_q;
        err_count_d       = err_count_q;
        first_err_valid_d = first_err_valid_q;
        first_err_idx_d   = first_err_idx_q;
        tt_cap_d          = tt_cap_q;
        gen_clear         = 1'b0;
        gen_advance       = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d           = SWEEP;
                    gen_clear         = 1'b1;
                    err_count_d       = '0;
                    first_err_valid_d = 1'b0;
                    first_err_idx_d   = '0;
                    tt_cap_d          = '0;
                end
            end
            SWEEP: begin
                gen_advance = 1'b1;
                // fut_out is only trusted once the vector has settled.
                if (sample_now) begin
                    tt_cap_d[vec] = bus.fut_out;
                    if (bus.fut_out != EXP_TT[vec]) begin
                        err_count_d = err_count_q + (N_IN+1)'(1);
                        if (!first_err_valid_q) begin
                            first_err_valid_d = 1'b1;
                            first_err_idx_d   = vec;
                        end
                    end
                    if (last) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            err_count_q       <= '0;
            first_err_valid_q <= 1'b0;
            first_err_idx_q   <= '0;
            tt_cap_q          <= '0;
        end else begin
            state_q           <= state_d;
            err_count_q       <= err_count_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_idx_q   <= first_err_idx_d;
            tt_cap_q          <= tt_cap_d;
        end
    end

    assign bus.vec             = vec;
    assign bus.busy            = (state_q == SWEEP);
    assign bus.done            = (state_q == DONE);
    assign bus.pass            = (state_q == DONE) && (err_count_q == '0);
    assign bus.err_count       = err_count_q;
    assign bus.first_err_valid = first_err_valid_q;
    assign bus.first_err_idx   = first_err_idx_q;
    assign bus.tt_cap          = tt_cap_q;

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Bench for minterm_sweep_checker: randomized FUT faults/glitches scored against a truth-table model.
module tb_minterm_sweep_checker;
    import lab_tt_pkg::*;

    localparam int NV = NUM_VEC;

    // Lab golden function, a = v[6] ... g = v[0].
    function automatic logic gold_fn(input logic [6:0] v);
        logic a, b, c, d, e, f, g;
        {a, b, c, d, e, f, g} = v;
        return (a & ~b & c) | (~d & e) | (b & f & ~g) | ((a ^ g) & d);
    endfunction

    function automatic logic [NV-1:0] gold_tt_fn();
        logic [NV-1:0] t;
        for (int i = 0; i < NV; i++) t[i] = gold_fn(7'(i));
        return t;
    endfunction

    localparam logic [NV-1:0] GOLD_TT = gold_tt_fn();
    localparam logic [NV-1:0] FLIP_TT = GOLD_TT ^ (NV'(1) << 8'h55);

    logic          clk = 1'b0;
    logic          rst_a, rst_b;
    logic          glitch_a;
    logic [NV-1:0] fmask;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    minterm_sweep_checker_if #(.N_IN(7)) bus_a ();
    minterm_sweep_checker_if #(.N_IN(7)) bus_b ();

    assign bus_a.fut_out = gold_fn(bus_a.vec) ^ fmask[bus_a.vec] ^ glitch_a;
    assign bus_b.fut_out = gold_fn(bus_b.vec);

    minterm_sweep_checker #(.N_IN(7), .SETTLE_CYCLES(1), .EXP_TT(GOLD_TT)) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    minterm_sweep_checker #(.N_IN(7), .SETTLE_CYCLES(0), .EXP_TT(FLIP_TT)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_idx(input logic [NV-1:0] m);
        for (int i = 0; i < NV; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic logic [NV-1:0] rand_mask();
        logic [NV-1:0] m;
        for (int i = 0; i < NV; i++) m[i] = ($urandom_range(0, 9) == 0);
        return m;
    endfunction

    // One sweep on the SETTLE_CYCLES=1 checker; results come from the fault mask alone.
    task automatic sweep_a(input string name, input logic [NV-1:0] mask, input bit glitch, input bit repulse);
        int cyc;
        int busy_cyc;
        fmask = mask;
        tick();
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        cyc = 0;
        busy_cyc = 0;
        while (bus_a.done !== 1'b1 && cyc < 600) begin
            if (bus_a.busy === 1'b1) busy_cyc++;
            glitch_a    = (glitch && (cyc % 2 == 0)) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_a.start = repulse && (cyc == 80);
            tick();
            cyc++;
        end
        glitch_a    = 1'b0;
        bus_a.start = 1'b0;
        chk({name, "_lat"},   128'(cyc), 128'(256));
        chk({name, "_busy"},  128'(busy_cyc), 128'(256));
        chk({name, "_done"},  128'(bus_a.done), 128'(1));
        chk({name, "_pass"},  128'(bus_a.pass), 128'(mask == '0));
        chk({name, "_err"},   128'(bus_a.err_count), 128'($countones(mask)));
        chk({name, "_fev"},   128'(bus_a.first_err_valid), 128'(mask != '0));
        chk({name, "_fei"},   128'(bus_a.first_err_idx), 128'(first_idx(mask)));
        chk({name, "_tt"},    bus_a.tt_cap, GOLD_TT ^ mask);
        chk({name, "_vec"},   128'(bus_a.vec), 128'(127));
        tick();
        chk({name, "_hold"},  128'({bus_a.done, bus_a.err_count}), 128'({1'b1, 8'($countones(mask))}));
    endtask

    initial begin
        int cyc;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        glitch_a = 1'b0;
        fmask = '0;
        repeat (3) tick();
        rst_a = 1'b0;
        rst_b = 1'b0;

        chk("rst_busy", 128'(bus_a.busy), 128'(0));
        chk("rst_done", 128'(bus_a.done), 128'(0));
        chk("rst_pass", 128'(bus_a.pass), 128'(0));
        chk("rst_err",  128'(bus_a.err_count), 128'(0));
        chk("rst_fev",  128'(bus_a.first_err_valid), 128'(0));
        chk("rst_fei",  128'(bus_a.first_err_idx), 128'(0));
        chk("rst_tt",   bus_a.tt_cap, 128'(0));
        chk("rst_vec",  128'(bus_a.vec), 128'(0));
        chk("rst_b_done", 128'({bus_b.busy, bus_b.done}), 128'(0));

        sweep_a("gold", '0, 1'b1, 1'b0);
        sweep_a("inv", '1, 1'b1, 1'b0);
        sweep_a("b55", NV'(1) << 8'h55, 1'b0, 1'b0);
        sweep_a("repulse", '0, 1'b0, 1'b1);

        // Reset at vector 40 together with start: reset must win.
        fmask = '1;
        tick();
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (cyc = 0; cyc < 80; cyc++) tick();
        chk("mid_err", 128'(bus_a.err_count), 128'(40));
        chk("mid_vec", 128'(bus_a.vec), 128'(40));
        rst_a = 1'b1;
        bus_a.start = 1'b1;
        tick();
        rst_a = 1'b0;
        bus_a.start = 1'b0;
        chk("abort_busy", 128'(bus_a.busy), 128'(0));
        chk("abort_done", 128'(bus_a.done), 128'(0));
        chk("abort_vec",  128'(bus_a.vec), 128'(0));
        chk("abort_err",  128'(bus_a.err_count), 128'(0));
        chk("abort_fev",  128'(bus_a.first_err_valid), 128'(0));
        chk("abort_tt",   bus_a.tt_cap, 128'(0));
        repeat (3) tick();
        chk("abort_idle", 128'({bus_a.busy, bus_a.done}), 128'(0));
        sweep_a("after_rst", '0, 1'b1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            sweep_a($sformatf("rnd%0d", r), rand_mask(), 1'b1, 1'($urandom_range(0, 1)));
        end

        // Back-to-back sweeps with start held high on the zero-settle checker.
        bus_b.start = 1'b1;
        tick();
        for (int s = 0; s < 3; s++) begin
            chk("b_clr_err",  128'(bus_b.err_count), 128'(0));
            chk("b_clr_fev",  128'(bus_b.first_err_valid), 128'(0));
            chk("b_busy",     128'(bus_b.busy), 128'(1));
            cyc = 0;
            while (bus_b.done !== 1'b1 && cyc < 400) begin
                tick();
                cyc++;
            end
            chk("b_lat",  128'(cyc), 128'(128));
            chk("b_err",  128'(bus_b.err_count), 128'(1));
            chk("b_fei",  128'(bus_b.first_err_idx), 128'(8'h55));
            chk("b_fev",  128'(bus_b.first_err_valid), 128'(1));
            chk("b_pass", 128'(bus_b.pass), 128'(0));
            chk("b_tt",   bus_b.tt_cap, GOLD_TT);
            tick();
            chk("b_done_1cyc", 128'(bus_b.done), 128'(0));
        end
        bus_b.start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
